// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Purpose  : Direct-mapped BTB with 2-bit counters; trains from EX and raises
//            a registered flush/redirect on mispredict.
// Revision : 1.0
// ============================================================================
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_branch,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    input  logic        branch_out,
    input  logic        ex_stall,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_count,
    output logic [31:0] mis_count
);
    localparam int         TAG_W       = 32 - IDX_W - 2;
    localparam logic [1:0] c_CTR_INIT  = 2'b01;
    localparam logic [1:0] c_CTR_ALLOC = 2'b10;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];

    logic        r_flush;
    logic [31:0] r_redirect_pc;
    logic [31:0] r_br_count;
    logic [31:0] r_mis_count;

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_ex_hit;
    logic             w_resolve;
    logic             w_mispredict;
    logic [31:0]      w_correct_pc;

    assign w_if_idx    = if_pc[IDX_W+1:2];
    assign w_if_tag    = if_pc[31:IDX_W+2];
    assign w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign pred_taken  = w_if_hit && r_ctr[w_if_idx][1];
    assign pred_target = w_if_hit ? r_target[w_if_idx] : (if_pc + 32'd4);

    assign w_ex_idx = ex_pc[IDX_W+1:2];
    assign w_ex_tag = ex_pc[31:IDX_W+2];
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

    // A branch sitting in EX while a flush is out is wrong-path and ignored.
    assign w_resolve    = ex_branch && !ex_stall && !r_flush;
    assign w_mispredict = (ex_pred_taken != branch_out) ||
                          (ex_pred_taken && branch_out && (ex_pred_target != ex_target));
    assign w_correct_pc = branch_out ? ex_target : (ex_pc + 32'd4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= c_CTR_INIT;
            end
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
            r_br_count    <= '0;
            r_mis_count   <= '0;
        end else begin
            r_flush <= w_resolve && w_mispredict;
            if (w_resolve) begin
                if (w_ex_hit) begin
                    if (branch_out) begin
                        if (r_ctr[w_ex_idx] != 2'b11)
                            r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
                        r_target[w_ex_idx] <= ex_target;
                    end else if (r_ctr[w_ex_idx] != 2'b00) begin
                        r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
                    end
                end else if (branch_out) begin
                    r_valid[w_ex_idx]  <= 1'b1;
                    r_tag[w_ex_idx]    <= w_ex_tag;
                    r_target[w_ex_idx] <= ex_target;
                    r_ctr[w_ex_idx]    <= c_CTR_ALLOC;
                end
                if (r_br_count != 32'hFFFF_FFFF)
                    r_br_count <= r_br_count + 32'd1;
                if (w_mispredict) begin
                    r_redirect_pc <= w_correct_pc;
                    if (r_mis_count != 32'hFFFF_FFFF)
                        r_mis_count <= r_mis_count + 32'd1;
                end
            end
        end
    end

    assign flush       = r_flush;
    assign redirect_pc = r_redirect_pc;
    assign br_count    = r_br_count;
    assign mis_count   = r_mis_count;

endmodule
`default_nettype wire
